ram_port_arbiter: RTL and testbench

//  Shares the single-port player-progress RAM (8-bit addr/data) between up to NUM_REQ requesters
//  (level saver, level loader, high-score logger, display reader).
//  - One transaction in flight: accepts one request at a time, drives the RAM, returns a per-requester

---
 rtl/ram_arb_pkg.sv | 27 ++
 rtl/ram_port_arbiter_if.sv | 37 +++
 rtl/ram_port_arbiter_rr_pick.sv | 29 ++
 rtl/ram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: FSM states, R/W encoding
// and the wait-counter width helper.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: packed per-requester
// request fields, one-hot grant/completion and the shared read-data bus.
interface ram_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req,
    output req_we,
    output req_addr,
    output req_wdata,
    input  gnt,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output gnt,
    output rsp_valid,
    output rsp_rdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational picker: first requester found scanning from
// start+1 upward, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] winner,
  output logic          any_valid
);

  logic [IW-1:0] idx;

  // Scan farthest-first so the nearest hit overwrites the result.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(start) + k) % N);
      if (req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM among NUM_REQ requesters, one access at a time.
// Define RAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  ram_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_r_w,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = clog2(READ_LAT + 1);

  localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);
  localparam logic [IW-1:0]      LAST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0]      WINIT = CW'(READ_LAT - 1);

  state_t        state;
  logic [IW-1:0] cur;
  logic          cur_we;
  logic [CW-1:0] wcnt;
  logic [IW-1:0] start;
  logic [IW-1:0] win;
  logic          any_req;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign start = LAST;
`else
  logic [IW-1:0] rr_ptr;

  assign start = rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= LAST;
    end else if (state == RESP) begin
      rr_ptr <= cur;
    end
  end
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req       (bus.req),
    .start     (start),
    .winner    (win),
    .any_valid (any_req)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cur           <= '0;
      cur_we        <= RW_READ;
      wcnt          <= '0;
      busy          <= 1'b0;
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      ram_en        <= 1'b0;
      ram_r_w       <= RW_READ;
      ram_addr      <= '0;
      ram_wdata     <= '0;
    end else begin
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      ram_en        <= 1'b0;
      ram_r_w       <= RW_READ;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            cur       <= win;
            cur_we    <= bus.req_we[win];
            bus.gnt   <= ONE << win;
            ram_en    <= 1'b1;
            ram_r_w   <= bus.req_we[win];
            ram_addr  <=
              bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
            ram_wdata <=
              bus.req_wdata[int'(win)*DATA_W +: DATA_W];
          end
        end
        ISSUE: begin
          if (cur_we == RW_WRITE) begin
            state         <= RESP;
            bus.rsp_valid <= ONE << cur;
          end else begin
            state <= WAIT;
            wcnt  <= WINIT;
          end
        end
        WAIT: begin
          // Last wait cycle: RAM data is valid now.
          if (wcnt == '0) begin
            state         <= RESP;
            bus.rsp_valid <= ONE << cur;
            bus.rsp_rdata <= ram_rdata;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed and random requester traffic
// against a transaction scoreboard and a cycle-level timing reference.
module tb_ram_port_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 3;
  localparam logic [N-1:0] ONE = 1;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_r_w;
  logic          ram_en;
  logic          busy;

  ram_port_arbiter_if #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) bus ();

  ram_port_arbiter #(
    .NUM_REQ  (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .READ_LAT (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_r_w   (ram_r_w),
    .ram_en    (ram_en),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] mm   [256];
  logic [DW-1:0] pipe [LAT];
  exp_t          q    [N][$];
  int            glog [$];
  int            g0cyc[$];

  bit            armed = 1'b0;
  bit            prev_rst = 1'b0;
  bit            m_idle = 1'b1;
  int            m_owner = 0;
  int            m_gcyc = -1;
  int            m_dcyc = -1;
  int            m_last = N - 1;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_rd = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first pending index after the last winner.
  function automatic int pick(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++) begin
      if (r[(lst + k) % N]) return (lst + k) % N;
    end
    return 0;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic ram_model();
    logic          en;
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      en = ram_en;
      rw = ram_r_w;
      a  = ram_addr;
      d  = ram_wdata;
      @(posedge clk);
      #1;
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      if (en === 1'b1 && rw === 1'b1) mem[a] = d;
      else if (en === 1'b1) pipe[0] = mem[a];
      ram_rdata = pipe[LAT-1];
    end
  endtask

  task automatic monitor();
    logic [N-1:0] eg;
    logic [N-1:0] ev;
    exp_t         e;
    int           w;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_rst) begin
        armed = 1'b1;
        chk("reset_outputs",
            {busy, bus.gnt, bus.rsp_valid, ram_en, ram_r_w,
             ram_addr, ram_wdata, bus.rsp_rdata}, '0);
      end
      if (armed) begin
        eg = (m_gcyc == cyc) ? (ONE << m_owner) : '0;
        ev = (m_dcyc == cyc) ? (ONE << m_owner) : '0;
        chk("busy", busy, !m_idle);
        chk("gnt", bus.gnt, eg);
        chk("ram_en", ram_en, m_gcyc == cyc);
        chk("rsp_valid", bus.rsp_valid, ev);
        if (m_gcyc == cyc) begin
          glog.push_back(m_owner);
          if (m_owner == 0) g0cyc.push_back(cyc);
          chk("ram_r_w", ram_r_w, m_we);
          chk("ram_addr", ram_addr, m_addr);
          if (m_we) chk("ram_wdata", ram_wdata, m_wd);
        end else begin
          chk("ram_r_w_idle", ram_r_w, 1'b0);
        end
        if (m_dcyc == cyc) begin
          chk("scoreboard_underflow", q[m_owner].size() == 0, 1'b0);
          if (q[m_owner].size() != 0) begin
            e = q[m_owner].pop_front();
            if (!e.we) m_rd = e.d;
            chk("rsp_rdata", bus.rsp_rdata, m_rd);
          end
        end
      end
      if (reset) begin
        if (!m_idle && m_dcyc > cyc && q[m_owner].size() != 0)
          void'(q[m_owner].pop_front());
        m_idle = 1'b1;
        m_gcyc = -1;
        m_dcyc = -1;
        m_last = N - 1;
        m_rd   = '0;
      end else if (m_dcyc == cyc) begin
        m_idle = 1'b1;
`ifndef RAM_ARB_FIXED_PRIO_EN
        m_last = m_owner;
`endif
      end else if (m_idle && bus.req != '0) begin
        w       = pick(bus.req, m_last);
        m_owner = w;
        m_idle  = 1'b0;
        m_we    = bus.req_we[w];
        m_addr  = bus.req_addr[w*AW +: AW];
        m_wd    = bus.req_wdata[w*DW +: DW];
        m_gcyc  = cyc + 1;
        m_dcyc  = cyc + 2 + (m_we ? 0 : LAT);
      end
      prev_rst = reset;
    end
  endtask

  // Called just after a posedge; returns just after the posedge
  // following the grant, with req dropped.
  task automatic issue(input int id, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    int   k;
    bit   got;
    bus.req_we[id]              = we;
    bus.req_addr[id*AW +: AW]   = a;
    bus.req_wdata[id*DW +: DW]  = d;
    bus.req[id]                 = 1'b1;
    e.we = we;
    if (we) begin
      mm[a] = d;
      e.d   = d;
    end else begin
      e.d = mm[a];
    end
    q[id].push_back(e);
    k   = 0;
    got = 1'b0;
    while (!got && k < 300) begin
      @(negedge clk);
      k++;
      if (bus.gnt[id]) got = 1'b1;
    end
    chk("gnt_timeout", !got, 1'b0);
    @(posedge clk);
    #1;
    bus.req[id] = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 300 && !(m_idle && all_empty())) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", k >= 300, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_rand(input int id);
    logic [AW-1:0] a;
    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      a = {2'(id), 3'b000, 3'($urandom_range(0, 7))};
      issue(id, 1'($urandom), a, 8'($urandom));
    end
  endtask

  task automatic run_pair(input int id);
    issue(id, 1'b1, {2'(id), 6'h20}, 8'(id + 8'h30));
    issue(id, 1'b0, {2'(id), 6'h20}, 8'h00);
  endtask

  initial begin
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      mm[i]  = mem[i];
    end
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    fork
      monitor();
      ram_model();
    join_none
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single write, then read back the same location.
    issue(2, 1'b1, 8'h02, 8'h05);
    issue(2, 1'b0, 8'h02, 8'h00);
    wait_idle();

    // Requester 1 arrives while requester 3's read is waiting.
    issue(3, 1'b0, 8'hC5, 8'h00);
    issue(1, 1'b0, 8'h02, 8'h00);
    wait_idle();

    // All four requesting continuously from reset.
    glog.delete();
    pulse_reset();
    fork
      run_pair(0);
      run_pair(1);
      run_pair(2);
      run_pair(3);
    join
    wait_idle();
    chk("rr_count", glog.size(), 8);
    for (int i = 0; i < glog.size() && i < 8; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk("fixed_order", glog[i], i / 2);
`else
      chk("rr_order", glog[i], i % N);
`endif
    end

    // Reset lands in the middle of a read wait.
    issue(0, 1'b0, 8'h10, 8'h00);
    pulse_reset();
    wait_idle();
    issue(1, 1'b1, 8'h44, 8'hA5);
    issue(1, 1'b0, 8'h44, 8'h00);
    wait_idle();

    // Eight back-to-back writes from requester 0.
    g0cyc.delete();
    for (int i = 0; i < 8; i++) begin
      issue(0, 1'b1, 8'(8'h08 + i), 8'($urandom));
    end
    wait_idle();
    chk("wr_count", g0cyc.size(), 8);
    for (int i = 1; i < g0cyc.size(); i++) begin
      chk("wr_spacing", g0cyc[i] - g0cyc[i-1], 3);
    end

    // Random mixed traffic on disjoint address ranges.
    fork
      run_rand(0);
      run_rand(1);
      run_rand(2);
      run_rand(3);
    join
    wait_idle();
    chk("scoreboard_left", all_empty(), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
